mem_arbiter: RTL and testbench

// - Shares one memory port between the instruction-cache (M0) and data-cache (M1) refill/writeback masters.
// - Grants at most one request at a time, round-robin. Holds a single outstanding transaction and routes its

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_arb2.sv | 19 +
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: request payload and FSM state.
package MemArbPkg;

   localparam int unsigned MEM_ADDR_WIDTH = 64;
   localparam int unsigned MEM_DATA_WIDTH = 256;
   localparam int unsigned MEM_STRB_WIDTH = MEM_DATA_WIDTH / 8;

   // One cache-line request as latched for the slave
   typedef struct packed {
      logic [MEM_ADDR_WIDTH-1:0] addr;
      logic                      wen;
      logic [MEM_DATA_WIDTH-1:0] wdata;
      logic [MEM_STRB_WIDTH-1:0] wmask;
   } mem_req_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0] : request vector (bit 1 = M1, bit 0 = M0)
//   last     : master granted most recently (1 = M1)
//   gnt[1:0] : one-hot grant, or zero when nothing is requested
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // A lone requester always wins; on a tie the master not granted last wins
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-cache (M0) and D-cache (M1)
// masters. One outstanding transaction; its reply is routed back to the owner.
//   clk, rstn              : clock, asynchronous active-low reset
//   mX_req_*               : master X request (valid/ready, addr, wen, wdata, wmask)
//   mX_resp_*              : master X reply (valid/ready, rdata)
//   s_req_*                : registered request toward the memory slave
//   s_resp_*               : slave reply, passed through to the owner
//   busy                   : a transaction is in flight
module mem_arbiter
   import MemArbPkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
   parameter bit          M1_FIRST   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    m0_req_valid,
   output logic                    m0_req_ready,
   input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
   input  logic                    m0_req_wen,
   input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_req_wmask,
   output logic                    m0_resp_valid,
   input  logic                    m0_resp_ready,
   output logic [DATA_WIDTH-1:0]   m0_resp_rdata,
   input  logic                    m1_req_valid,
   output logic                    m1_req_ready,
   input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
   input  logic                    m1_req_wen,
   input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_req_wmask,
   output logic                    m1_resp_valid,
   input  logic                    m1_resp_ready,
   output logic [DATA_WIDTH-1:0]   m1_resp_rdata,
   output logic                    s_req_valid,
   input  logic                    s_req_ready,
   output logic [ADDR_WIDTH-1:0]   s_req_addr,
   output logic                    s_req_wen,
   output logic [DATA_WIDTH-1:0]   s_req_wdata,
   output logic [DATA_WIDTH/8-1:0] s_req_wmask,
   input  logic                    s_resp_valid,
   output logic                    s_resp_ready,
   input  logic [DATA_WIDTH-1:0]   s_resp_rdata,
   output logic                    busy
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   arb_state_t state_q, state_d;
   mem_req_t   req_q, req_d;
   logic       owner_q, owner_d;
   logic       last_grant_q, last_grant_d;
   logic [1:0] gnt;
   logic       owner_resp_ready;
   logic       resp_hs;
   logic       accept;

   rr_arb2 u_rr_arb2 (
      .req  ({m1_req_valid, m0_req_valid}),
      .last (last_grant_q),
      .gnt  (gnt)
   );

   assign owner_resp_ready = owner_q ? m1_resp_ready : m0_resp_ready;
   assign resp_hs          = s_resp_valid & owner_resp_ready;
   assign accept           = (state_q == IDLE) && (gnt != 2'b00);

   // State and latched-request registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         req_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= ~M1_FIRST;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (gnt != 2'b00) state_d = SEND;
         SEND:    if (s_req_ready)  state_d = WAIT;
         WAIT:    if (resp_hs)      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the winner's fields and ownership on acceptance
   always_comb begin
      req_d        = req_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         owner_d      = gnt[1];
         last_grant_d = gnt[1];
         if (gnt[1]) begin
            req_d.addr  = MEM_ADDR_WIDTH'(m1_req_addr);
            req_d.wen   = m1_req_wen;
            req_d.wdata = MEM_DATA_WIDTH'(m1_req_wdata);
            req_d.wmask = MEM_STRB_WIDTH'(m1_req_wmask);
         end else begin
            req_d.addr  = MEM_ADDR_WIDTH'(m0_req_addr);
            req_d.wen   = m0_req_wen;
            req_d.wdata = MEM_DATA_WIDTH'(m0_req_wdata);
            req_d.wmask = MEM_STRB_WIDTH'(m0_req_wmask);
         end
      end
   end

   // Handshake outputs; the reply path is a pure pass-through to the owner
   always_comb begin
      m0_req_ready  = 1'b0;
      m1_req_ready  = 1'b0;
      s_req_valid   = 1'b0;
      s_resp_ready  = 1'b0;
      m0_resp_valid = 1'b0;
      m1_resp_valid = 1'b0;
      m0_resp_rdata = s_resp_rdata;
      m1_resp_rdata = s_resp_rdata;
      unique case (state_q)
         IDLE: begin
            m0_req_ready = gnt[0];
            m1_req_ready = gnt[1];
         end
         SEND: s_req_valid = 1'b1;
         WAIT: begin
            s_resp_ready  = owner_resp_ready;
            m0_resp_valid = ~owner_q & s_resp_valid;
            m1_resp_valid = owner_q & s_resp_valid;
         end
         default: ;
      endcase
   end

   assign s_req_addr  = ADDR_WIDTH'(req_q.addr);
   assign s_req_wen   = req_q.wen;
   assign s_req_wdata = DATA_WIDTH'(req_q.wdata);
   assign s_req_wmask = STRB_WIDTH'(req_q.wmask);
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, single read, tie-break order,
// write, backpressure, asynchronous reset mid-transaction, back-to-back rate.
module tb_mem_arbiter;

   logic         clk, rstn;
   logic         m0_req_valid, m0_req_ready, m0_req_wen, m0_resp_valid, m0_resp_ready;
   logic [63:0]  m0_req_addr;
   logic [255:0] m0_req_wdata, m0_resp_rdata;
   logic [31:0]  m0_req_wmask;
   logic         m1_req_valid, m1_req_ready, m1_req_wen, m1_resp_valid, m1_resp_ready;
   logic [63:0]  m1_req_addr;
   logic [255:0] m1_req_wdata, m1_resp_rdata;
   logic [31:0]  m1_req_wmask;
   logic         s_req_valid, s_req_ready, s_req_wen, s_resp_valid, s_resp_ready;
   logic [63:0]  s_req_addr;
   logic [255:0] s_req_wdata, s_resp_rdata;
   logic [31:0]  s_req_wmask;
   logic         busy;

   int checks   = 0;
   int failures = 0;
   logic mon_en = 1'b1;
   logic pend0  = 1'b0;
   logic pend1  = 1'b0;

   logic [255:0] pat_a5;
   logic [255:0] pat_de;

   mem_arbiter dut (
      .clk(clk), .rstn(rstn),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
      .m0_req_wen(m0_req_wen), .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask),
      .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp_rdata(m0_resp_rdata),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
      .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
      .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp_rdata(m1_resp_rdata),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
      .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
      .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_rdata(s_resp_rdata),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Masters must hold req_valid until accepted
   always @(negedge clk) begin
      if (!rstn || !mon_en) begin
         pend0 = 1'b0;
         pend1 = 1'b0;
      end else begin
         if (pend0) begin
            checks++;
            if (!m0_req_valid) begin failures++; $display("FAIL m0_valid_dropped before ready"); end
         end
         if (pend1) begin
            checks++;
            if (!m1_req_valid) begin failures++; $display("FAIL m1_valid_dropped before ready"); end
         end
         pend0 = m0_req_valid && !m0_req_ready;
         pend1 = m1_req_valid && !m1_req_ready;
      end
   end

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #3;
      rstn = 1'b1;
      cyc();
   endtask

   // Current state is SEND with s_req_ready=1: finish the transaction back to IDLE
   task automatic complete_txn();
      s_req_ready = 1'b1;
      cyc();
      s_resp_valid = 1'b1;
      cyc();
      s_resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      m0_req_valid = 0; m0_req_addr = '0; m0_req_wen = 0; m0_req_wdata = '0; m0_req_wmask = '0; m0_resp_ready = 0;
      m1_req_valid = 0; m1_req_addr = '0; m1_req_wen = 0; m1_req_wdata = '0; m1_req_wmask = '0; m1_resp_ready = 0;
      s_req_ready = 0; s_resp_valid = 0; s_resp_rdata = '0;
      #12;
      checks++;
      if ({busy, s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid} !== 7'b0) begin
         failures++; $display("FAIL reset_outputs got %b expected 0000000",
            {busy, s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid});
      end
      checks++;
      if (s_req_addr !== 64'h0 || s_req_wen !== 1'b0 || s_req_wmask !== 32'h0) begin
         failures++; $display("FAIL reset_fields addr=%h wen=%b wmask=%h expected 0", s_req_addr, s_req_wen, s_req_wmask);
      end
      rstn = 1'b1;
      cyc();
   endtask

   task automatic test_single_read();
      m0_req_valid = 1; m0_req_addr = 64'h8000_0040; m0_req_wen = 0; m0_resp_ready = 1; s_req_ready = 1;
      @(negedge clk);
      checks++;
      if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0 || s_req_valid !== 1'b0) begin
         failures++; $display("FAIL read_accept m0_rdy=%b m1_rdy=%b s_valid=%b expected 1 0 0", m0_req_ready, m1_req_ready, s_req_valid);
      end
      cyc();
      m0_req_valid = 0;
      @(negedge clk);
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 64'h8000_0040 || s_req_wen !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL read_send s_valid=%b addr=%h wen=%b busy=%b expected 1 8000_0040 0 1", s_req_valid, s_req_addr, s_req_wen, busy);
      end
      cyc();
      s_resp_valid = 1; s_resp_rdata = pat_a5;
      @(negedge clk);
      checks++;
      if (m0_resp_valid !== 1'b1 || m1_resp_valid !== 1'b0 || m0_resp_rdata !== pat_a5 || s_resp_ready !== 1'b1 || s_req_valid !== 1'b0) begin
         failures++; $display("FAIL read_reply m0v=%b m1v=%b s_rr=%b s_v=%b rdata=%h", m0_resp_valid, m1_resp_valid, s_resp_ready, s_req_valid, m0_resp_rdata);
      end
      cyc();
      s_resp_valid = 0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m0_resp_valid !== 1'b0) begin
         failures++; $display("FAIL read_done busy=%b m0v=%b expected 0 0", busy, m0_resp_valid);
      end
      cyc();
   endtask

   task automatic test_tie();
      do_reset();
      m0_req_valid = 1; m0_req_addr = 64'h100; m0_req_wen = 0;
      m1_req_valid = 1; m1_req_addr = 64'h200; m1_req_wen = 0;
      m0_resp_ready = 1; m1_resp_ready = 1; s_req_ready = 1;
      @(negedge clk);
      checks++;
      if ({m1_req_ready, m0_req_ready} !== 2'b10) begin
         failures++; $display("FAIL tie_first got m1,m0 ready=%b expected 10", {m1_req_ready, m0_req_ready});
      end
      cyc();
      m1_req_valid = 0;
      @(negedge clk);
      checks++;
      if (s_req_addr !== 64'h200 || m0_req_ready !== 1'b0) begin
         failures++; $display("FAIL tie_first_send addr=%h m0_rdy=%b expected 200 0", s_req_addr, m0_req_ready);
      end
      cyc();
      s_resp_valid = 1;
      @(negedge clk);
      checks++;
      if ({m1_resp_valid, m0_resp_valid} !== 2'b10) begin
         failures++; $display("FAIL tie_first_reply m1v,m0v=%b expected 10", {m1_resp_valid, m0_resp_valid});
      end
      cyc();
      s_resp_valid = 0;
      @(negedge clk);
      checks++;
      if ({m1_req_ready, m0_req_ready} !== 2'b01) begin
         failures++; $display("FAIL tie_second got m1,m0 ready=%b expected 01", {m1_req_ready, m0_req_ready});
      end
      cyc();
      m0_req_valid = 0;
      @(negedge clk);
      checks++;
      if (s_req_addr !== 64'h100) begin
         failures++; $display("FAIL tie_second_send addr=%h expected 100", s_req_addr);
      end
      complete_txn();
      m0_req_valid = 1; m1_req_valid = 1;
      @(negedge clk);
      checks++;
      if ({m1_req_ready, m0_req_ready} !== 2'b10) begin
         failures++; $display("FAIL tie_third got m1,m0 ready=%b expected 10", {m1_req_ready, m0_req_ready});
      end
      cyc();
      m1_req_valid = 0;
      complete_txn();
      @(negedge clk);
      checks++;
      if ({m1_req_ready, m0_req_ready} !== 2'b01) begin
         failures++; $display("FAIL tie_fourth got m1,m0 ready=%b expected 01", {m1_req_ready, m0_req_ready});
      end
      cyc();
      m0_req_valid = 0;
      complete_txn();
   endtask

   task automatic test_write();
      m1_req_valid = 1; m1_req_addr = 64'h1000; m1_req_wen = 1;
      m1_req_wdata = 256'h1234; m1_req_wmask = 32'hFFFF_FFFF; m1_resp_ready = 1; s_req_ready = 1;
      @(negedge clk);
      checks++;
      if (m1_req_ready !== 1'b1) begin failures++; $display("FAIL write_accept m1_rdy=%b expected 1", m1_req_ready); end
      cyc();
      m1_req_valid = 0; m1_req_wen = 0;
      @(negedge clk);
      checks++;
      if (s_req_valid !== 1'b1 || s_req_wen !== 1'b1 || s_req_addr !== 64'h1000 ||
          s_req_wdata !== 256'h1234 || s_req_wmask !== 32'hFFFF_FFFF) begin
         failures++; $display("FAIL write_send v=%b wen=%b addr=%h wdata=%h wmask=%h", s_req_valid, s_req_wen, s_req_addr, s_req_wdata, s_req_wmask);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (m1_resp_valid !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL write_wait m1v=%b busy=%b expected 0 1", m1_resp_valid, busy);
      end
      cyc();
      s_resp_valid = 1;
      @(negedge clk);
      checks++;
      if (m1_resp_valid !== 1'b1 || m0_resp_valid !== 1'b0) begin
         failures++; $display("FAIL write_ack m1v=%b m0v=%b expected 1 0", m1_resp_valid, m0_resp_valid);
      end
      cyc();
      s_resp_valid = 0;
      @(negedge clk);
      checks++;
      if (m1_resp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL write_done m1v=%b busy=%b expected 0 0", m1_resp_valid, busy);
      end
      cyc();
   endtask

   task automatic test_backpressure();
      m0_req_valid = 1; m0_req_addr = 64'h2000; m0_req_wen = 0; m0_resp_ready = 0; s_req_ready = 0;
      @(negedge clk);
      checks++;
      if (m0_req_ready !== 1'b1) begin failures++; $display("FAIL bp_accept m0_rdy=%b expected 1", m0_req_ready); end
      cyc();
      m0_req_valid = 0;
      m1_req_valid = 1; m1_req_addr = 64'h3000; m1_req_wen = 0; m1_resp_ready = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (s_req_valid !== 1'b1 || s_req_addr !== 64'h2000 || m1_req_ready !== 1'b0) begin
            failures++; $display("FAIL bp_req_stall[%0d] v=%b addr=%h m1_rdy=%b expected 1 2000 0", i, s_req_valid, s_req_addr, m1_req_ready);
         end
         cyc();
      end
      s_req_ready = 1;
      cyc();
      s_resp_valid = 1; s_resp_rdata = pat_de;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (m0_resp_valid !== 1'b1 || s_resp_ready !== 1'b0 || m0_resp_rdata !== pat_de || busy !== 1'b1) begin
            failures++; $display("FAIL bp_resp_stall[%0d] m0v=%b s_rr=%b busy=%b rdata=%h", i, m0_resp_valid, s_resp_ready, busy, m0_resp_rdata);
         end
         cyc();
      end
      m0_resp_ready = 1;
      @(negedge clk);
      checks++;
      if (s_resp_ready !== 1'b1) begin failures++; $display("FAIL bp_resp_release s_rr=%b expected 1", s_resp_ready); end
      cyc();
      s_resp_valid = 0;
      @(negedge clk);
      checks++;
      if ({m1_req_ready, m0_req_ready} !== 2'b10) begin
         failures++; $display("FAIL bp_next_grant m1,m0 ready=%b expected 10", {m1_req_ready, m0_req_ready});
      end
      cyc();
      m1_req_valid = 0;
      complete_txn();
   endtask

   task automatic test_reset_mid_wait();
      m1_req_valid = 1; m1_req_addr = 64'h4000; m1_req_wen = 0; m1_resp_ready = 1; s_req_ready = 1;
      cyc();
      m1_req_valid = 0;
      cyc();
      s_resp_valid = 1; s_resp_rdata = pat_a5; m1_resp_ready = 0;
      #2;
      checks++;
      if (m1_resp_valid !== 1'b1 || busy !== 1'b1) begin
         failures++; $display("FAIL rst_pre m1v=%b busy=%b expected 1 1", m1_resp_valid, busy);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({busy, s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid} !== 7'b0) begin
         failures++; $display("FAIL rst_mid_wait got %b expected 0000000",
            {busy, s_req_valid, s_resp_ready, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid});
      end
      s_resp_valid = 0; m1_resp_ready = 1;
      #2;
      rstn = 1'b1;
      cyc();
      m0_req_valid = 1; m0_req_addr = 64'h5000;
      m1_req_valid = 1; m1_req_addr = 64'h6000;
      @(negedge clk);
      checks++;
      if ({m1_req_ready, m0_req_ready} !== 2'b10) begin
         failures++; $display("FAIL rst_fresh_tie m1,m0 ready=%b expected 10", {m1_req_ready, m0_req_ready});
      end
      cyc();
      m1_req_valid = 0;
      complete_txn();
      cyc();
      m0_req_valid = 0;
      complete_txn();
   endtask

   task automatic test_back_to_back();
      int grants;
      logic [1:0] exp_g;
      grants = 0;
      do_reset();
      m0_req_valid = 1; m1_req_valid = 1; m0_req_wen = 0; m1_req_wen = 0;
      m0_resp_ready = 1; m1_resp_ready = 1; s_req_ready = 1; s_resp_valid = 1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (c % 3 == 0) exp_g = ((c / 3) % 2 == 0) ? 2'b10 : 2'b01;
         else            exp_g = 2'b00;
         if ({m1_req_ready, m0_req_ready} != 2'b00) grants++;
         checks++;
         if ({m1_req_ready, m0_req_ready} !== exp_g) begin
            failures++; $display("FAIL b2b_grant[%0d] m1,m0 ready=%b expected %b", c, {m1_req_ready, m0_req_ready}, exp_g);
         end
         cyc();
      end
      checks++;
      if (grants != 20) begin failures++; $display("FAIL b2b_count got %0d grants expected 20", grants); end
      mon_en = 0;
      m0_req_valid = 0; m1_req_valid = 0; s_resp_valid = 0;
      do_reset();
   endtask

   initial begin
      pat_a5 = {32{8'hA5}};
      pat_de = {8{32'hDEAD_BEEF}};
      test_reset();
      test_single_read();
      test_tie();
      test_write();
      test_backpressure();
      test_reset_mid_wait();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
